// File: rtl/pll_reset_pkg.sv
// rtl/pll_reset_pkg.sv - shared state encoding and parameter defaults for the PLL reset sequencer
package pll_reset_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RUN       = 2'd2
  } pll_state_e;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_HOLD_CYCLES    = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1048576;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop synchronizer with asynchronous active-low reset
module sync_ff #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[DEPTH-2:0], d};
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - qualifies PLL lock and sequences the reset of PLL-clocked logic
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       soft_req,
  output logic       rst_out_n,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] loss_count,
  output logic       timeout
);

  localparam int CW = $clog2(max3(STABLE_CYCLES, HOLD_CYCLES, TIMEOUT_CYCLES)) + 1;
  localparam logic [CW-1:0] STABLE_C  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] HOLD_C    = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT_CYCLES);

  logic          lock_s;
  pll_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    loss_q, loss_d;
  logic          timeout_q, timeout_d;

  sync_ff #(.DEPTH(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tcnt_d    = '0;
    loss_d    = loss_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        tcnt_d = (tcnt_q == '1) ? tcnt_q : tcnt_q + 1'b1;
        if (tcnt_d >= TIMEOUT_C) timeout_d = 1'b1;
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_inc == STABLE_C) begin
          state_d   = ST_HOLD;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_inc == HOLD_C) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RUN: begin
        // Lock loss takes priority over a simultaneous soft request
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
          loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
        end else if (soft_req) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_WAIT_LOCK;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      loss_q    <= '0;
      timeout_q <= 1'b0;
      rst_out_n <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      loss_q    <= loss_d;
      timeout_q <= timeout_d;
      rst_out_n <= (state_d == ST_RUN);
      ready     <= (state_d == ST_RUN);
    end
  end

  assign state      = state_q;
  assign loss_count = loss_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb/tb_pll_reset_seq.sv - directed self-checking bench for pll_reset_seq
module tb_pll_reset_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       soft_req;
  logic       rst_out_n;
  logic       ready;
  logic [1:0] state;
  logic [7:0] loss_count;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  pll_reset_seq #(
    .SYNC_STAGES    (2),
    .STABLE_CYCLES  (8),
    .HOLD_CYCLES    (4),
    .TIMEOUT_CYCLES (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .soft_req   (soft_req),
    .rst_out_n  (rst_out_n),
    .ready      (ready),
    .state      (state),
    .loss_count (loss_count),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Caller is at edge E with the FSM idle in WAIT_LOCK and lock low; RUN is due at E+14
  task automatic qualify(input string tag);
    pll_lock = 1'b1;
    step(13);
    check({tag, "_e13_rst"}, rst_out_n, 0);
    check({tag, "_e13_state"}, state, 1);
    step(1);
    check({tag, "_e14_rst"}, rst_out_n, 1);
    check({tag, "_e14_ready"}, ready, 1);
    check({tag, "_e14_state"}, state, 2);
  endtask

  initial begin
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    soft_req = 1'b0;
    step(3);
    check("rst_rst_out_n", rst_out_n, 0);
    check("rst_ready", ready, 0);
    check("rst_state", state, 0);
    check("rst_loss", loss_count, 0);
    check("rst_timeout", timeout, 0);

    rst_n = 1'b1;
    step(1);
    qualify("qual1");
    check("qual1_timeout", timeout, 0);

    pll_lock = 1'b0;
    step(2);
    check("loss_t2_rst", rst_out_n, 1);
    step(1);
    check("loss_t3_rst", rst_out_n, 0);
    check("loss_t3_state", state, 0);
    check("loss_t3_count", loss_count, 1);
    check("loss_t3_ready", ready, 0);

    soft_req = 1'b1;
    step(1);
    soft_req = 1'b0;
    check("soft_ignored_state", state, 0);
    step(1);
    check("soft_ignored_state2", state, 0);

    qualify("qual2");

    soft_req = 1'b1;
    step(1);
    soft_req = 1'b0;
    check("soft_s1_state", state, 1);
    check("soft_s1_rst", rst_out_n, 0);
    step(3);
    check("soft_s4_rst", rst_out_n, 0);
    step(1);
    check("soft_s5_rst", rst_out_n, 1);
    check("soft_s5_state", state, 2);

    pll_lock = 1'b0;
    step(2);
    soft_req = 1'b1;
    step(1);
    soft_req = 1'b0;
    check("softloss_state", state, 0);
    check("softloss_count", loss_count, 2);
    check("softloss_rst", rst_out_n, 0);

    step(1);
    pll_lock = 1'b1;
    step(6);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(7);
    check("glitch_e14_rst", rst_out_n, 0);
    step(6);
    check("glitch_e20_rst", rst_out_n, 0);
    check("glitch_e20_state", state, 1);
    step(1);
    check("glitch_e21_rst", rst_out_n, 1);
    check("glitch_e21_state", state, 2);

    #3;
    rst_n = 1'b0;
    #1;
    check("arst_rst_out_n", rst_out_n, 0);
    check("arst_ready", ready, 0);
    check("arst_loss", loss_count, 0);
    check("arst_state", state, 0);
    pll_lock = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(31);
    check("tmo_31", timeout, 0);
    step(1);
    check("tmo_32", timeout, 1);
    step(8);
    check("tmo_held", timeout, 1);
    pll_lock = 1'b1;
    step(9);
    check("tmo_e9_timeout", timeout, 1);
    check("tmo_e9_state", state, 0);
    step(1);
    check("tmo_e10_timeout", timeout, 0);
    check("tmo_e10_state", state, 1);
    step(3);
    check("tmo_e13_rst", rst_out_n, 0);
    step(1);
    check("tmo_e14_rst", rst_out_n, 1);
    check("tmo_e14_ready", ready, 1);

    for (int i = 0; i < 256; i++) begin
      pll_lock = 1'b0;
      step(3);
      check("sat_count", loss_count, (i + 1 > 255) ? 255 : i + 1);
      pll_lock = 1'b1;
      step(14);
      if (i == 255) check("sat_final_state", state, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for pll_lock (min 2).
REQ-002 Parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock-high cycles required before hold phase (min 1).
REQ-003 Parameter HOLD_CYCLES, default 16: cycles rst_out_n stays low after lock qualified (min 1).
REQ-004 Parameter TIMEOUT_CYCLES, default 1048576: cycles in WAIT_LOCK before timeout flag (min 1).
REQ-005 Port clk  input  1  free-running reference clock (PLL input clock, never the PLL output).
REQ-006 Port rst_n  input  1  asynchronous, active-low reset.
REQ-007 Port pll_lock  input  1  PLL LOCK output, asynchronous to clk.
REQ-008 Port soft_req  input  1  single-cycle request to re-run hold phase.
REQ-009 Port rst_out_n  output  1  registered active-low reset for PLL-clocked logic.
REQ-010 Port ready  output  1  high only in RUN.
REQ-011 Port state  output  2  current state encoding.
REQ-012 Port loss_count  output  8  saturating count of lock losses in RUN.
REQ-013 Port timeout  output  1  sticky flag: no qualified lock within TIMEOUT_CYCLES.

Function
REQ-014 pll_lock SHALL pass through SYNC_STAGES flops to give lock_s; no other logic samples pll_lock.
REQ-015 States SHALL be WAIT_LOCK=0, HOLD=1, RUN=2; encoding 3 unused, decodes to WAIT_LOCK next cycle.
REQ-016 WAIT_LOCK: stable counter increments each cycle lock_s=1, clears to 0 on any lock_s=0 cycle; on reaching STABLE_CYCLES -> HOLD with counter cleared.
REQ-017 HOLD: counter increments each cycle; on reaching HOLD_CYCLES -> RUN; lock_s=0 in HOLD -> WAIT_LOCK, loss_count unchanged.
REQ-018 RUN: lock_s=0 -> WAIT_LOCK and loss_count increments, saturating at 255; soft_req=1 with lock_s=1 -> HOLD, counter cleared.
REQ-019 Lock loss and soft_req in same RUN cycle: lock loss wins (WAIT_LOCK, count incremented).
REQ-020 soft_req SHALL be ignored outside RUN.
REQ-021 rst_out_n and ready SHALL be registered: 1 exactly in cycles where state=RUN, 0 otherwise, no combinational path from any input.
REQ-022 With pll_lock held high from edge E, rst_out_n SHALL rise at edge E+SYNC_STAGES+STABLE_CYCLES+HOLD_CYCLES.
REQ-023 rst_out_n SHALL fall on the edge at which state leaves RUN, i.e. SYNC_STAGES+1 edges after pll_lock sampled low.
REQ-024 Timeout counter: counts cycles spent in WAIT_LOCK, cleared on entering WAIT_LOCK, saturates; timeout sets when it reaches TIMEOUT_CYCLES.
REQ-025 timeout SHALL stay set until transition WAIT_LOCK -> HOLD, then clear on that edge.
REQ-026 Counter widths SHALL be clog2 of the largest parameter +1; no wrap-around permitted.

Reset
REQ-027 rst_n low SHALL asynchronously force: synchronizer flops 0, state=WAIT_LOCK, counters 0, rst_out_n=0, ready=0, loss_count=0, timeout=0.
REQ-028 Reset mid-HOLD or mid-RUN SHALL drop rst_out_n immediately (asynchronously) and restart qualification after rst_n release.

Structure
REQ-029 State encoding constants and parameter defaults SHALL live in shared package pll_reset_pkg.
REQ-030 Synchronizer SHALL be a separate sub-module sync_ff (parameterized depth, async active-low reset); the FSM and counters stay in pll_reset_seq.

Verification (SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=4, TIMEOUT_CYCLES=32)
REQ-031 Release rst_n, pll_lock=1 from edge 0 -> rst_out_n and ready rise at edge 14, state=2.
REQ-032 pll_lock glitches low 1 cycle at edge 6 -> stable count restarts; rst_out_n rises at edge 14 + (cycles elapsed through the glitch), never early.
REQ-033 In RUN, pll_lock low at edge T -> rst_out_n falls at T+3, loss_count 0->1; 256 losses -> loss_count stays 255.
REQ-034 pll_lock held 0 -> timeout=1 after 32 cycles in WAIT_LOCK; then pll_lock=1 -> timeout clears on entering HOLD.
REQ-035 In RUN, soft_req pulse -> rst_out_n low for exactly 4 cycles; soft_req with simultaneous lock loss -> WAIT_LOCK, loss_count+1.
REQ-036 rst_n asserted during RUN -> rst_out_n=0 asynchronously, loss_count=0; re-release -> 14-cycle qualification repeats.
